vedic8_seq_ctrl: RTL
====================

// Module: vedic8_seq_ctrl
// PURPOSE
//  Sequencer that computes an 8x8 approximate product on ONE shared NVM_4bit (4x4 approx Vedic) core.
//  Issues the four nibble partial products over successive cycles, shift-accumulates them, returns a 16-bit result.
//  Sits between the DCT coefficient/sample fetch logic and the butterfly adders; valid/ready on both sides.
// PARAMETERS
//  PIPE_PP   0   1: register core output before accumulate (+1 cycle per step); 0: accumulate core output directly
//  ACC_W     16  accumulator/result width; must be 16 (checked at elaboration)
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   synchronous active-low reset
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   high only in IDLE
//  a          in   8   multiplicand, unsigned
//  b          in   8   multiplier, unsigned
//  out_valid  out  1   p valid; held until accepted
//  out_ready  in   1   downstream accepts p
//  p          out  16  approximate product
//  busy       out  1   high in any state but IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE, acc=0, step=0, p=0, out_valid=0, busy=0; in_ready=1 from first cycle after reset.
//  - Reset mid-operation: abort, discard operands/acc, no out_valid; same values as above.
//  - FSM states: IDLE -> MUL -> DONE -> IDLE.
//  - IDLE: in_valid&&in_ready latches a,b into a_r,b_r; acc<=0; step<=0; -> MUL. in_valid ignored elsewhere.
//  - MUL: step 0..3 drives core {xa,xb}: 0:{aL,bL} sh0, 1:{aH,bL} sh4, 2:{aL,bH} sh4, 3:{aH,bH} sh8.
//    acc <= acc + ({8'b0,pp} << sh), modulo 2^16 (wrap, no saturate).
//  - MUL step timing: one step per cycle (PIPE_PP=0); one core cycle + one accumulate cycle per step (PIPE_PP=1).
//  - MUL exit: after step 3 -> DONE; p<=final acc, out_valid<=1.
//  - Latency, accept edge = cycle N: out_valid first high at N+5 (PIPE_PP=0) / N+9 (PIPE_PP=1).
//  - DONE: p,out_valid stable while out_ready=0; out_valid&&out_ready -> IDLE, out_valid<=0 next edge.
//  - Next accept no earlier than cycle after output handshake; max throughput 1 result / 6 cycles (PIPE_PP=0).
//  - Core input is muxed from a_r/b_r only; live a/b changing during MUL has no effect.
//  - Core is the only multiplier; no exact correction of approximate partial products.
// CONFIGURATION
//  - Macro VEDIC8_ZERO_SKIP_EN.
//  - Defined: at accept and after each step, skip every remaining step whose a- or b-nibble is 4'h0.
//    Skipped steps contribute 0. If no steps remain, go directly to DONE.
//    Latency = N + 1 + (non-skipped steps)*(1+PIPE_PP); a=0 or b=0 gives out_valid at N+1... N+2.
//    Precisely: zero steps -> out_valid at N+2, p=0.
//  - Undefined: all four steps always run; fixed latency as above; p values are identical in both builds.
// TESTING
//  1. a=8'h12,b=8'h21 (no 2-bit field =3, core exact), PIPE_PP=0 -> out_valid at N+5, p=16'h0252.
//  2. a=8'hFF,b=8'hFF -> p equals golden model sum of four NVM_4bit products shifted 0/4/4/8, mod 2^16.
//  3. Backpressure: hold out_ready=0 for 10 cycles after case 1.
//     -> p=16'h0252 and out_valid stable; in_ready=0 throughout; in_valid pulses ignored.
//  4. Reset mid-op: assert rst_n=0 at step 2 of a=8'h33,b=8'h77
//     -> next cycle out_valid=0, p=0, busy=0, in_ready=1; no stale result afterwards.
//  5. VEDIC8_ZERO_SKIP_EN, a=8'h05,b=8'h02 -> only step 0 runs, out_valid at N+2, p=16'h000A.
//     Same stimulus without macro -> N+5, p=16'h000A.
//  6. Back-to-back: in_valid held high with 3 operand pairs, out_ready=1
//     -> accepts spaced 6 cycles apart, results in order, each matches golden model.

Source files
------------

// File: rtl/vedic8_seq_ctrl_if.sv
// Operand/result handshake bundle for vedic8_seq_ctrl.
// master = fetch/butterfly side, slave = the sequencer.
interface vedic8_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/vedic8_seq_ctrl.sv
// 8x8 approximate multiply sequenced over one shared 4x4 approximate Vedic core.
// Optional macro VEDIC8_ZERO_SKIP_EN skips partial products with a zero nibble.
module vedic8_seq_ctrl #(
  parameter int unsigned PIPE_PP = 0,
  parameter int unsigned ACC_W   = 16
) (
  input logic             clk,
  input logic             rst_n,
  vedic8_seq_ctrl_if.slave bus
);

  if (ACC_W != 16) begin : g_acc_w_check
    $error("vedic8_seq_ctrl: ACC_W must be 16");
  end

  localparam bit Pipe = (PIPE_PP != 0);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e             state_q, state_d;
  logic [7:0]         a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]   acc_q, acc_d, p_q, p_d;
  logic [2:0]         step_q, step_d;
  logic               phase_q, phase_d;
  logic [7:0]         pp_q, pp_d;
  logic               out_valid_q, out_valid_d;

  // 2x2 approximate block: 3*3 yields 7 instead of 9.
  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'b11 && y == 2'b11) return 4'd7;
    return {2'b00, x} * {2'b00, y};
  endfunction

  function automatic logic [7:0] nvm_4bit(input logic [3:0] x, input logic [3:0] y);
    return {4'b0, mul2(x[1:0], y[1:0])}
         + ({4'b0, mul2(x[3:2], y[1:0])} << 2)
         + ({4'b0, mul2(x[1:0], y[3:2])} << 2)
         + ({4'b0, mul2(x[3:2], y[3:2])} << 4);
  endfunction

  // Lowest live step at or after 'from'; 4 means none remain.
  function automatic logic [2:0] first_live(input logic [3:0] live, input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int s = 3; s >= 0; s--) begin
      if (live[s] && (3'(s) >= from)) r = 3'(s);
    end
    return r;
  endfunction

  logic [3:0] live_in, live_r;
`ifdef VEDIC8_ZERO_SKIP_EN
  // Bit s marks step s as non-zero: {aH&bH, aL&bH, aH&bL, aL&bL}.
  assign live_in = {(|bus.a[7:4]) & (|bus.b[7:4]), (|bus.a[3:0]) & (|bus.b[7:4]),
                    (|bus.a[7:4]) & (|bus.b[3:0]), (|bus.a[3:0]) & (|bus.b[3:0])};
  assign live_r  = {(|a_q[7:4]) & (|b_q[7:4]), (|a_q[3:0]) & (|b_q[7:4]),
                    (|a_q[7:4]) & (|b_q[3:0]), (|a_q[3:0]) & (|b_q[3:0])};
`else
  assign live_in = 4'hF;
  assign live_r  = 4'hF;
`endif

  logic [3:0]       xa, xb, shamt;
  logic [7:0]       pp, pp_src;
  logic [ACC_W-1:0] term;

  always_comb begin
    xa     = step_q[0] ? a_q[7:4] : a_q[3:0];
    xb     = step_q[1] ? b_q[7:4] : b_q[3:0];
    pp     = nvm_4bit(xa, xb);
    pp_src = Pipe ? pp_q : pp;
    unique case (step_q[1:0])
      2'b00:   shamt = 4'd0;
      2'b11:   shamt = 4'd8;
      default: shamt = 4'd4;
    endcase
    term = ACC_W'(pp_src) << shamt;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    step_d      = step_q;
    phase_d     = phase_q;
    pp_d        = pp_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          step_d  = first_live(live_in, 3'd0);
          phase_d = 1'b0;
          state_d = StMul;
        end
      end
      StMul: begin
        if (step_q[2]) begin
          // Everything skipped at accept: finish with an empty accumulator.
          state_d     = StDone;
          p_d         = acc_q;
          out_valid_d = 1'b1;
        end else if (Pipe && !phase_q) begin
          pp_d    = pp;
          phase_d = 1'b1;
        end else begin
          acc_d   = acc_q + term;
          phase_d = 1'b0;
          step_d  = first_live(live_r, step_q + 3'd1);
          if (step_d[2]) begin
            state_d     = StDone;
            p_d         = acc_d;
            out_valid_d = 1'b1;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      step_q      <= '0;
      phase_q     <= 1'b0;
      pp_q        <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      phase_q     <= phase_d;
      pp_q        <= pp_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;

endmodule
